// File: rtl/uart_rx_buffer_pkg.sv
// ============================================================================
// Module      : uart_rx_buffer_pkg
// Description : Shared UART constants and the capture FSM state encoding used
//               by the receive buffer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_buffer_pkg;

    // Byte width delivered by the receiver's data_out.
    localparam int UART_DATA_W   = 8;
    // 100 MHz / 76.8 kHz : baud divisor used by the receiver/transmitter pair.
    localparam int UART_BAUD_DIV = 1302;

    // Capture FSM: one push per new_data assertion.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } cap_state_t;

endpackage : uart_rx_buffer_pkg

`default_nettype wire

// File: rtl/uart_rx_buffer_mem.sv
// ============================================================================
// Module      : uart_rx_buffer_mem
// Description : DEPTH x DATA_W storage for the receive FIFO. One synchronous
//               write port, one asynchronous read port (show-ahead head).
//               Storage is not reset; occupancy is tracked by the parent.
// Ports       : clk    - system clock
//               we     - write enable
//               waddr  - write address (AW bits)
//               wdata  - write data
//               raddr  - read address (AW bits)
//               rdata  - combinational read data
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer_mem #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : uart_rx_buffer_mem

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module      : uart_rx_buffer
// Description : Downstream stage of the UART receiver. Captures bytes on the
//               data_out/new_data/read handshake into a DEPTH-entry FIFO and
//               presents the head entry to the CPU as show-ahead read data.
// Macro       : UART_RXBUF_STATUS_EN - adds overflow/drop_cnt/ovf_clr ports
//               and the drop-tracking registers behind them.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous reset, active-low
//               rx_data     - receiver data_out
//               rx_new_data - receiver new_data (level, held until acked)
//               rx_read     - acknowledge to receiver
//               rd_en       - CPU pops the head entry
//               rd_data     - head entry, valid when empty==0 (0 when empty)
//               empty/full  - occupancy flags derived from count
//               count       - occupancy 0..DEPTH
//               overflow    - sticky drop flag            (status build)
//               drop_cnt    - saturating dropped-byte count (status build)
//               ovf_clr     - clears overflow and drop_cnt  (status build)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_new_data,
    output logic              rx_read,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
`ifdef UART_RXBUF_STATUS_EN
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              ovf_clr,
`endif
    output logic [AW:0]       count
);

    localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] w_mem_rdata;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte is sampled only on the IDLE->ACK transition, so a long
    // new_data level yields exactly one capture.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (rx_new_data) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!rx_new_data) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign rx_read = (r_state == ST_ACK);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign empty = (r_count == '0);
    assign full  = (r_count == C_FULL_COUNT);
    assign count = r_count;

    // Pop only when something is there; a pop while full frees the slot
    // that a same-cycle capture then fills.
    assign w_pop  = rd_en && !empty;
    assign w_push = w_capture && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    uart_rx_buffer_mem #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk    (clk),
        .we     (w_push),
        .waddr  (r_wr_ptr),
        .wdata  (rx_data),
        .raddr  (r_rd_ptr),
        .rdata  (w_mem_rdata)
    );

    // Force a defined value while empty so reset shows rd_data=0 even though
    // the storage itself is not cleared.
    assign rd_data = empty ? '0 : w_mem_rdata;

    // ------------------------------------------------------------------
    // Optional drop tracking
    // ------------------------------------------------------------------
`ifdef UART_RXBUF_STATUS_EN
    logic       w_drop;
    logic       r_overflow;
    logic [7:0] r_drop_cnt;

    assign w_drop = w_capture && !w_push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            // Clear wins over a drop in the same cycle.
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule : uart_rx_buffer

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Directed self-checking bench for uart_rx_buffer. Drives the
//               receiver handshake and CPU pop side with hand-computed
//               expected values.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_new_data;
    logic       rx_read;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef UART_RXBUF_STATUS_EN
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       ovf_clr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_buffer #(
        .DEPTH  (16),
        .AW     (4),
        .DATA_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .rx_read     (rx_read),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
`ifdef UART_RXBUF_STATUS_EN
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .ovf_clr     (ovf_clr),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver-side handshake: raise new_data, wait (bounded) for read,
    // drop new_data, wait (bounded) for read to fall.
    task automatic send_hs(input logic [7:0] b);
        int n;
        rx_data     = b;
        rx_new_data = 1'b1;
        n = 0;
        while (!rx_read && n < 10) begin
            step();
            n++;
        end
        chk("hs_ack", 32'(rx_read), 32'd1);
        rx_new_data = 1'b0;
        n = 0;
        while (rx_read && n < 10) begin
            step();
            n++;
        end
        chk("hs_release", 32'(rx_read), 32'd0);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        rx_data     = 8'h00;
        rx_new_data = 1'b0;
        rd_en       = 1'b0;
`ifdef UART_RXBUF_STATUS_EN
        ovf_clr     = 1'b0;
`endif
        #1;

        // ---- 1. reset ----
        repeat (3) step();
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
`ifdef UART_RXBUF_STATUS_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b1;
        step();

        // ---- 2. single byte, new_data held 5 clk ----
        rx_data     = 8'hB9;
        rx_new_data = 1'b1;
        step();
        chk("b9_count_1clk", 32'(count),   32'd1);
        chk("b9_rd_data",    32'(rd_data), 32'hB9);
        chk("b9_rx_read",    32'(rx_read), 32'd1);
        repeat (4) step();
        chk("b9_no_dup",     32'(count),   32'd1);
        chk("b9_read_held",  32'(rx_read), 32'd1);
        rx_new_data = 1'b0;
        step();
        chk("b9_read_fall",  32'(rx_read), 32'd0);
        chk("b9_count_hold", 32'(count),   32'd1);
        pop_chk("b9_pop", 8'hB9);
        chk("b9_empty", 32'(empty), 32'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pop_empty_ignored", 32'(count), 32'd0);

        // ---- 3. fill 00..0F, drain, wrap ----
        for (int i = 0; i < 16; i++) begin
            send_hs(8'(i));
            if (i == 14) begin
                chk("fill15_count", 32'(count), 32'd15);
                chk("fill15_full",  32'(full),  32'd0);
            end
        end
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop_chk("drain_seq", 8'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        send_hs(8'h8E);
        chk("wrap_count", 32'(count), 32'd1);
        pop_chk("wrap_data", 8'h8E);
        chk("wrap_empty", 32'(empty), 32'd1);

        // ---- 4. push+pop while full ----
        for (int i = 0; i < 16; i++) begin
            send_hs(8'(8'h10 + i));
        end
        chk("pp_full_before", 32'(full), 32'd1);
        rx_data     = 8'hAA;
        rx_new_data = 1'b1;
        rd_en       = 1'b1;
        step();
        rd_en       = 1'b0;
        rx_new_data = 1'b0;
        chk("pp_count", 32'(count),   32'd16);
        chk("pp_head",  32'(rd_data), 32'h11);
`ifdef UART_RXBUF_STATUS_EN
        chk("pp_no_drop", 32'(overflow), 32'd0);
`endif
        step();
        for (int i = 1; i < 16; i++) begin
            pop_chk("pp_seq", 8'(8'h10 + i));
        end
        pop_chk("pp_last_aa", 8'hAA);
        chk("pp_empty", 32'(empty), 32'd1);

        // ---- 5. overflow: 3 pushes while full ----
        for (int i = 0; i < 16; i++) begin
            send_hs(8'(8'h20 + i));
        end
        send_hs(8'hC1);
        send_hs(8'hC2);
        send_hs(8'hC3);
        chk("ovf_count", 32'(count), 32'd16);
`ifdef UART_RXBUF_STATUS_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt",  32'(drop_cnt), 32'd3);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_flag", 32'(overflow), 32'd0);
        chk("ovf_clr_cnt",  32'(drop_cnt), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            pop_chk("ovf_seq", 8'(8'h20 + i));
        end
        chk("ovf_empty", 32'(empty), 32'd1);

        // ---- 6. reset while in ACK with count=5 ----
        for (int i = 0; i < 4; i++) begin
            send_hs(8'(8'h50 + i));
        end
        rx_data     = 8'h55;
        rx_new_data = 1'b1;
        step();
        chk("ack_count5",  32'(count),   32'd5);
        chk("ack_rx_read", 32'(rx_read), 32'd1);
        rst = 1'b0;
        step();
        chk("rst_mid_count", 32'(count),   32'd0);
        chk("rst_mid_empty", 32'(empty),   32'd1);
        chk("rst_mid_read",  32'(rx_read), 32'd0);
        rst = 1'b1;
        step();
        chk("recap_count", 32'(count),   32'd1);
        chk("recap_data",  32'(rd_data), 32'h55);
        chk("recap_read",  32'(rx_read), 32'd1);
        rx_new_data = 1'b0;
        step();
        pop_chk("recap_pop", 8'h55);

        // ---- 7. end to end: two bytes in order ----
        send_hs(8'hB9);
        send_hs(8'h8E);
        chk("e2e_count", 32'(count), 32'd2);
        pop_chk("e2e_first",  8'hB9);
        pop_chk("e2e_second", 8'h8E);
        chk("e2e_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_rx_buffer

`default_nettype wire
